cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive dcache words completed while icache waits before grant is forced to icache.
REQ-002 SHALL have reset nRST, asynchronous, active-low, and clock CLK.
REQ-003 CLK  in  1  system clock.
REQ-004 nRST  in  1  async active-low reset.
REQ-005 iREN  in  1  icache read request; iaddr  in  32  icache word address.
REQ-006 iwait  out  1  icache stall, low for exactly the cycle its word completes; iload  out  32  icache read data.
REQ-007 dREN, dWEN  in  1 each  dcache read/write request; daddr  in  32; dstore  in  32  write data.
REQ-008 dwait  out  1  dcache stall, low for exactly the completing cycle; dload  out  32  dcache read data.
REQ-009 ramREN, ramWEN  out  1 each; ramaddr  out  32; ramstore  out  32; ramload  in  32  RAM read data.
REQ-010 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-011 icount, dcount  out  32 each  words completed per requester (wrapping).

Function
REQ-012 States: IDLE, IGNT, DGNT; state register updates on CLK rising edge.
REQ-013 IDLE: dcache request (dREN|dWEN) -> DGNT; else iREN -> IGNT; else stay; simultaneous requests go to DGNT.
REQ-014 IDLE drives ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-015 IGNT: ram port = {iREN, 0, iaddr, 0}; iwait = !(ramstate==ACCESS); dwait=1.
REQ-016 DGNT: ram port = {dREN, dWEN, daddr, dstore}; dwait = !(ramstate==ACCESS); iwait=1.
REQ-017 If dREN and dWEN are both high, ramWEN=1 and ramREN=0 (write wins).
REQ-018 iload and dload SHALL both equal ramload combinationally at all times.
REQ-019 Word completion = granted state AND its request high AND ramstate==ACCESS; BUSY, FREE and ERROR all keep wait high.
REQ-020 IGNT exit: on icache completion -> DGNT if dcache requesting, else IDLE; on iREN low without completion -> IDLE.
REQ-021 DGNT holds while dREN|dWEN is high, including WEN->REN switches between words, so multi-word block transfers stay atomic.
REQ-022 DGNT exit: request low -> IDLE (or IGNT if iREN high); on completion with starve counter == STARVE_LIMIT-1 and iREN high -> IGNT.
REQ-023 Starve counter (3-bit min): increments on each dcache completion while iREN is high; clears on entering IGNT or when iREN is low.
REQ-024 A forced switch SHALL NOT drop the in-flight dcache word; the dcache keeps dwait=1 and resumes on return to DGNT.
REQ-025 icount/dcount increment by 1 on each completion of the respective requester; wrap 0xFFFFFFFF->0.
REQ-026 Request withdrawn mid-access (no ACCESS seen): no completion counted, no wait pulse, state exits per REQ-020/022.

Reset
REQ-027 nRST low SHALL force state=IDLE, starve counter=0, icount=dcount=0 immediately, regardless of clock.
REQ-028 During and after reset until first grant: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
REQ-029 Reset mid-transfer SHALL abandon the access with no completion pulse.

Structure
REQ-030 ramstate_t enum SHALL reside in cpu_types_pkg; arbiter state enum stays local to the module.
REQ-031 STARVE_LIMIT is a module parameter, not a package constant.
REQ-032 Single module with no sub-module; output logic is combinational from registered state.

Verification
REQ-033 iREN only, addr 0x40, ACCESS after 2 BUSY cycles -> IDLE->IGNT, iwait low 1 cycle, iload=ramload, icount=1.
REQ-034 iREN and dREN high same cycle in IDLE -> DGNT first; dcache completes, then IGNT; dcount=1 then icount=1.
REQ-035 dWEN word 0x100 then dREN 0x104 back-to-back, iREN high throughout, STARVE_LIMIT=4 -> DGNT held for both words, no icache grant in between.
REQ-036 dREN held for 4 words with iREN high -> after 4th completion state=IGNT, dwait=1 until icache word completes.
REQ-037 ramstate=ERROR for 5 cycles in DGNT -> dwait stays 1, no count change; then ACCESS -> single completion.
REQ-038 nRST pulsed low mid-DGNT with ramstate=BUSY -> state=IDLE, ram outputs 0, counters 0, no wait-low pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the memory arbiter and its neighbours.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates a single RAM port between icache and dcache. The dcache is preferred, but
// the icache is guaranteed a grant after STARVE_LIMIT consecutive dcache words.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  // statistics
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  localparam int unsigned SW = (STARVE_LIMIT > 8) ? $clog2(STARVE_LIMIT) : 3;
  localparam logic [SW-1:0] StarveLast = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   icount_q, dcount_q;

  logic d_req;
  logic i_done;
  logic d_done;

  assign d_req  = dREN | dWEN;
  assign i_done = (state_q == IGNT) && iREN && (ramstate == ACCESS);
  assign d_done = (state_q == DGNT) && d_req && (ramstate == ACCESS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req)     state_d = DGNT;
        else if (iREN) state_d = IGNT;
      end
      IGNT: begin
        if (i_done)     state_d = d_req ? DGNT : IDLE;
        else if (!iREN) state_d = IDLE;
      end
      DGNT: begin
        // Holding DGNT while any dcache request is up keeps block transfers atomic.
        if (!d_req)                                          state_d = iREN ? IGNT : IDLE;
        else if (d_done && iREN && (starve_q == StarveLast)) state_d = IGNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!iREN)                                      starve_d = '0;
    else if ((state_d == IGNT) && (state_q != IGNT)) starve_d = '0;
    else if (d_done)                                starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (i_done) icount_q <= icount_q + 32'd1;
      if (d_done) dcount_q <= dcount_q + 32'd1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state_q)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !i_done;
      end
      DGNT: begin
        // A simultaneous read and write request is treated as a write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !d_done;
      end
      default: ;
    endcase
  end

  assign iload  = ramload;
  assign dload  = ramload;
  assign icount = icount_q;
  assign dcount = dcount_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grant order, starvation switch, errors and reset.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;
  ramstate_t   ramstate;

  int n_vec = 0;
  int n_err = 0;

  cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .icount   (icount),
    .dcount   (dcount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #3;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramren", 32'(ramREN), 32'd0);
    chk("rst_ramwen", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_icount", icount, 32'h0);
    chk("rst_dcount", dcount, 32'h0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // icache alone, two BUSY cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #1;
    chk("i_idle_addr", ramaddr, 32'h0);
    tick();
    chk("i_gnt_addr", ramaddr, 32'h40);
    chk("i_gnt_ren", 32'(ramREN), 32'd1);
    chk("i_busy1_wait", 32'(iwait), 32'd1);
    tick();
    chk("i_busy2_wait", 32'(iwait), 32'd1);
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("i_access_wait", 32'(iwait), 32'd0);
    chk("i_iload", iload, 32'hDEADBEEF);
    chk("i_dwait", 32'(dwait), 32'd1);
    tick();
    iREN = 1'b0; ramstate = FREE; #1;
    chk("i_icount", icount, 32'd1);
    chk("i_after_wait", 32'(iwait), 32'd1);
    chk("i_after_addr", ramaddr, 32'h0);

    // simultaneous requests: dcache first, then icache
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
    tick();
    chk("sim_daddr", ramaddr, 32'h200);
    chk("sim_dren", 32'(ramREN), 32'd1);
    chk("sim_iwait", 32'(iwait), 32'd1);
    ramstate = ACCESS; ramload = 32'h11112222; #1;
    chk("sim_dwait", 32'(dwait), 32'd0);
    chk("sim_dload", dload, 32'h11112222);
    tick();
    dREN = 1'b0; ramstate = BUSY; #1;
    chk("sim_dcount", dcount, 32'd1);
    chk("sim_icount_hold", icount, 32'd1);
    tick();
    chk("sim_igrant_addr", ramaddr, 32'h80);
    ramstate = ACCESS; #1;
    chk("sim_iwait", 32'(iwait), 32'd0);
    tick();
    iREN = 1'b0; ramstate = FREE; #1;
    chk("sim_icount", icount, 32'd2);

    // write then read back-to-back with icache waiting: DGNT held throughout
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE0001;
    ramstate = BUSY;
    tick();
    chk("blk_wen", 32'(ramWEN), 32'd1);
    chk("blk_ren", 32'(ramREN), 32'd0);
    chk("blk_addr0", ramaddr, 32'h100);
    chk("blk_store", ramstore, 32'hCAFE0001);
    ramstate = ACCESS; #1;
    chk("blk_w_dwait", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0; dREN = 1'b1; daddr = 32'h104; ramstate = BUSY; #1;
    chk("blk_addr1", ramaddr, 32'h104);
    chk("blk_ren1", 32'(ramREN), 32'd1);
    chk("blk_store1", ramstore, 32'hCAFE0001);
    chk("blk_dcount1", dcount, 32'd2);
    ramstate = ACCESS; ramload = 32'hA5A5A5A5; #1;
    chk("blk_dload", dload, 32'hA5A5A5A5);
    tick();
    dREN = 1'b0; iREN = 1'b0; ramstate = BUSY; #1;
    chk("blk_dcount2", dcount, 32'd3);
    chk("blk_icount", icount, 32'd2);
    tick();
    chk("blk_idle_addr", ramaddr, 32'h0);

    // four dcache words with icache waiting forces a switch to the icache
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    tick();
    for (int k = 0; k < 4; k++) begin
      ramstate = ACCESS; #1;
      chk("stv_dwait_low", 32'(dwait), 32'd0);
      tick();
      ramstate = BUSY; #1;
      if (k < 3) chk("stv_hold_d", ramaddr, 32'h300);
      else       chk("stv_to_i", ramaddr, 32'h80);
    end
    chk("stv_dcount", dcount, 32'd7);
    chk("stv_dwait_hi", 32'(dwait), 32'd1);
    ramstate = ACCESS; #1;
    chk("stv_iwait", 32'(iwait), 32'd0);
    chk("stv_dwait_i", 32'(dwait), 32'd1);
    tick();
    ramstate = BUSY; #1;
    chk("stv_icount", icount, 32'd3);
    chk("stv_resume", ramaddr, 32'h300);
    dREN = 1'b0; iREN = 1'b0;
    tick();

    // ERROR responses never complete; write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h55AA55AA; ramstate = ERROR;
    tick();
    chk("err_wen", 32'(ramWEN), 32'd1);
    chk("err_ren", 32'(ramREN), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("err_dwait", 32'(dwait), 32'd1);
      tick();
    end
    chk("err_dcount", dcount, 32'd7);
    ramstate = ACCESS; #1;
    chk("err_done", 32'(dwait), 32'd0);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
    chk("err_dcount1", dcount, 32'd8);
    tick();

    // asynchronous reset in the middle of a dcache access
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick();
    chk("rst2_pre", ramaddr, 32'h500);
    #2 nRST = 1'b0;
    #1;
    chk("rst2_addr", ramaddr, 32'h0);
    chk("rst2_ren", 32'(ramREN), 32'd0);
    chk("rst2_icount", icount, 32'h0);
    chk("rst2_dcount", dcount, 32'h0);
    ramstate = ACCESS;
    tick();
    chk("rst2_dwait", 32'(dwait), 32'd1);
    chk("rst2_dcount_edge", dcount, 32'h0);
    dREN = 1'b0; ramstate = FREE;
    nRST = 1'b1;
    tick();
    chk("rst2_after", dcount, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
